pat_hit_window_counter: RTL and testbench



---
 rtl/pat_pkg.sv | 14 +
 rtl/pat_win_timer.sv | 32 +++
 rtl/pat_hit_window_counter.sv | 117 +++++++++++
 tb/tb_pat_hit_window_counter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pat_pkg.sv
// Shared constants and encodings for the pattern-hit window counter.
// Imported by the window timer and the counter top.
package pat_pkg;

    localparam int PAT_WIN_LEN = 16;
    localparam int PAT_CNT_W   = 8;
    localparam int PAT_THRESH  = 4;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/pat_win_timer.sv
// Window position counter: advances on enabled cycles and flags the
// final cycle of each WIN_LEN-long window.
module pat_win_timer
    import pat_pkg::*;
#(
    parameter int WIN_LEN = PAT_WIN_LEN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clear,
    output logic win_end
);

    localparam int PW = $clog2(WIN_LEN);
    localparam logic [PW-1:0] LAST = PW'(WIN_LEN - 1);

    logic [PW-1:0] win_pos;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_pos <= '0;
        end else if (clear) begin
            win_pos <= '0;
        end else if (en) begin
            win_pos <= (win_pos == LAST) ? '0 : win_pos + PW'(1);
        end
    end

    assign win_end = en & ~clear & (win_pos == LAST);

endmodule

// File: rtl/pat_hit_window_counter.sv
// Counts detector hits per window and hands each window's saturating
// count to a host through a one-deep valid/ready result register.
module pat_hit_window_counter
    import pat_pkg::*;
#(
    parameter int WIN_LEN = PAT_WIN_LEN,
    parameter int CNT_W   = PAT_CNT_W,
    parameter int THRESH  = PAT_THRESH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             flag_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat,
    output logic             thresh_hit,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    logic             win_end;
    logic [CNT_W-1:0] hit_cnt;
    logic             sat;
    logic [CNT_W-1:0] fin_cnt;
    logic             fin_sat;
    logic             inc;
    out_state_e       state;
    out_state_e       state_nxt;
    logic             load;
    logic             ovr_set;

    pat_win_timer #(
        .WIN_LEN (WIN_LEN)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clear   (clear),
        .win_end (win_end)
    );

    // Count including this cycle's hit; on a window end this is the final value
    assign inc     = en & flag_in;
    assign fin_cnt = (inc && hit_cnt != MAX) ? hit_cnt + CNT_W'(1) : hit_cnt;
    assign fin_sat = sat | (fin_cnt == MAX);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovr_set   = 1'b0;
        unique case (state)
            OUT_EMPTY: begin
                if (win_end) begin
                    load      = 1'b1;
                    state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (win_end) begin
                    if (res_ready) begin
                        load = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end else if (res_ready) begin
                    state_nxt = OUT_EMPTY;
                end
            end
            default: state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= OUT_EMPTY;
            hit_cnt    <= '0;
            sat        <= 1'b0;
            res_count  <= '0;
            res_sat    <= 1'b0;
            thresh_hit <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            state      <= OUT_EMPTY;
            hit_cnt    <= '0;
            sat        <= 1'b0;
            res_count  <= '0;
            res_sat    <= 1'b0;
            thresh_hit <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            thresh_hit <= win_end & (fin_cnt >= THR);
            if (win_end) begin
                hit_cnt <= '0;
                sat     <= 1'b0;
            end else begin
                hit_cnt <= fin_cnt;
                sat     <= fin_sat;
            end
            if (load) begin
                res_count <= fin_cnt;
                res_sat   <= fin_sat;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

    assign res_valid = (state == OUT_FULL);

endmodule

// File: tb/tb_pat_hit_window_counter.sv
// Scenario bench for pat_hit_window_counter: expected window results are
// queued as windows are driven and popped when the DUT presents them.
module tb_pat_hit_window_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic       flag_in = 1'b0;
    logic       res_ready = 1'b0;
    logic       res_valid;
    logic [7:0] res_count;
    logic       res_sat;
    logic       thresh_hit;
    logic       overrun;
    logic       res_valid3;
    logic [2:0] res_count3;
    logic       res_sat3;
    logic       thresh_hit3;
    logic       overrun3;

    typedef struct {
        logic [7:0] cnt;
        logic       sat;
        logic       thr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pat_hit_window_counter #(.WIN_LEN(16), .CNT_W(8), .THRESH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .clear      (clear),
        .flag_in    (flag_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_count  (res_count),
        .res_sat    (res_sat),
        .thresh_hit (thresh_hit),
        .overrun    (overrun)
    );

    pat_hit_window_counter #(.WIN_LEN(16), .CNT_W(3), .THRESH(4)) dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .clear      (clear),
        .flag_in    (flag_in),
        .res_valid  (res_valid3),
        .res_ready  (res_ready),
        .res_count  (res_count3),
        .res_sat    (res_sat3),
        .thresh_hit (thresh_hit3),
        .overrun    (overrun3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        en = 1'b0;
        flag_in = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic drive_window(input logic [15:0] mask, input logic rdy);
        for (int i = 0; i < 16; i++) begin
            en = 1'b1;
            flag_in = mask[i];
            res_ready = rdy;
            tick();
        end
        en = 1'b0;
        flag_in = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({res_valid, res_count, res_sat, thresh_hit, overrun} !== 12'h0) begin
            errors++;
            $display("FAIL reset_init got=%b want=0",
                     {res_valid, res_count, res_sat, thresh_hit, overrun});
        end
        reset_n = 1'b1;
        drive_window(16'h0011, 1'b0);
        for (int i = 0; i < 6; i++) begin
            en = 1'b1;
            flag_in = (i % 2 == 0);
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, res_count, res_sat, thresh_hit, overrun} !== 12'h0) begin
            errors++;
            $display("FAIL reset_async got=%b want=0",
                     {res_valid, res_count, res_sat, thresh_hit, overrun});
        end
        en = 1'b0;
        flag_in = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.push_back('{cnt: 8'd2, sat: 1'b0, thr: 1'b0});
        drive_window(16'h0101, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, res_sat, thresh_hit} !== {1'b1, e.cnt, e.sat, e.thr}) begin
            errors++;
            $display("FAIL reset_after v=%b cnt=%0d sat=%b th=%b want cnt=%0d",
                     res_valid, res_count, res_sat, thresh_hit, e.cnt);
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_threshold();
        do_clear();
        checks++;
        if ({res_valid, res_count, thresh_hit, overrun} !== 11'h0) begin
            errors++;
            $display("FAIL clear_state got=%b want=0",
                     {res_valid, res_count, thresh_hit, overrun});
        end
        exp_q.push_back('{cnt: 8'd5, sat: 1'b0, thr: 1'b1});
        drive_window(16'h1113, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, res_sat, thresh_hit} !== {1'b1, e.cnt, e.sat, e.thr}) begin
            errors++;
            $display("FAIL thresh_met v=%b cnt=%0d sat=%b th=%b want cnt=%0d th=1",
                     res_valid, res_count, res_sat, thresh_hit, e.cnt);
        end
        tick();
        checks++;
        if ({res_valid, thresh_hit} !== 2'b00) begin
            errors++;
            $display("FAIL thresh_pulse v=%b th=%b want 00", res_valid, thresh_hit);
        end
    endtask

    task automatic test_last_cycle();
        do_clear();
        exp_q.push_back('{cnt: 8'd3, sat: 1'b0, thr: 1'b0});
        drive_window(16'h8208, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, res_sat, thresh_hit} !== {1'b1, e.cnt, e.sat, e.thr}) begin
            errors++;
            $display("FAIL last_cycle v=%b cnt=%0d th=%b want cnt=%0d th=0",
                     res_valid, res_count, thresh_hit, e.cnt);
        end
        exp_q.push_back('{cnt: 8'd0, sat: 1'b0, thr: 1'b0});
        drive_window(16'h0000, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, thresh_hit} !== {1'b1, e.cnt, e.thr}) begin
            errors++;
            $display("FAIL next_window v=%b cnt=%0d want cnt=%0d",
                     res_valid, res_count, e.cnt);
        end
    endtask

    task automatic test_overrun();
        do_clear();
        exp_q.push_back('{cnt: 8'd2, sat: 1'b0, thr: 1'b0});
        drive_window(16'h0003, 1'b0);
        checks++;
        if ({res_valid, thresh_hit, overrun} !== 3'b100) begin
            errors++;
            $display("FAIL ovr_winA v=%b th=%b ovr=%b want 100",
                     res_valid, thresh_hit, overrun);
        end
        drive_window(16'h007f, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, thresh_hit, overrun} !== {1'b1, e.cnt, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovr_winB v=%b cnt=%0d th=%b ovr=%b want cnt=%0d th=1 ovr=1",
                     res_valid, res_count, thresh_hit, overrun, e.cnt);
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if ({res_valid, overrun} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_drain v=%b ovr=%b want 01", res_valid, overrun);
        end
        tick();
        tick();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky ovr=%b want 1", overrun);
        end
        do_clear();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear ovr=%b want 0", overrun);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        exp_q.push_back('{cnt: 8'd16, sat: 1'b0, thr: 1'b1});
        drive_window(16'hffff, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, res_sat, thresh_hit} !== {1'b1, e.cnt, e.sat, e.thr}) begin
            errors++;
            $display("FAIL sat_wide v=%b cnt=%0d sat=%b th=%b want cnt=%0d",
                     res_valid, res_count, res_sat, thresh_hit, e.cnt);
        end
        checks++;
        if ({res_valid3, res_count3, res_sat3, thresh_hit3} !== {1'b1, 3'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sat_narrow v=%b cnt=%0d sat=%b th=%b want cnt=7 sat=1 th=1",
                     res_valid3, res_count3, res_sat3, thresh_hit3);
        end
    endtask

    task automatic test_enable();
        do_clear();
        exp_q.push_back('{cnt: 8'd6, sat: 1'b0, thr: 1'b1});
        res_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i >= 8 && i <= 17) begin
                en = 1'b0;
                flag_in = 1'b1;
            end else begin
                en = 1'b1;
                flag_in = (i % 3 == 0);
            end
            tick();
            if (i == 15) begin
                checks++;
                if (res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL en_stall res_valid=%b want 0 at cycle 16", res_valid);
                end
            end
        end
        en = 1'b0;
        flag_in = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, thresh_hit} !== {1'b1, e.cnt, e.thr}) begin
            errors++;
            $display("FAIL en_count v=%b cnt=%0d th=%b want cnt=%0d",
                     res_valid, res_count, thresh_hit, e.cnt);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            en = 1'b1;
            flag_in = 1'b1;
            tick();
        end
        do_clear();
        exp_q.push_back('{cnt: 8'd1, sat: 1'b0, thr: 1'b0});
        drive_window(16'h0400, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, thresh_hit} !== {1'b1, e.cnt, e.thr}) begin
            errors++;
            $display("FAIL clear_restart v=%b cnt=%0d want cnt=%0d",
                     res_valid, res_count, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        exp_q.push_back('{cnt: 8'd2, sat: 1'b0, thr: 1'b0});
        drive_window(16'h0005, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count} !== {1'b1, e.cnt}) begin
            errors++;
            $display("FAIL b2b_first v=%b cnt=%0d want cnt=%0d",
                     res_valid, res_count, e.cnt);
        end
        exp_q.push_back('{cnt: 8'd3, sat: 1'b0, thr: 1'b0});
        for (int i = 0; i < 16; i++) begin
            en = 1'b1;
            flag_in = (i < 3);
            res_ready = (i == 15);
            tick();
            if (i == 10) begin
                checks++;
                if ({res_valid, res_count} !== {1'b1, 8'd2}) begin
                    errors++;
                    $display("FAIL b2b_hold v=%b cnt=%0d want cnt=2", res_valid, res_count);
                end
            end
        end
        en = 1'b0;
        flag_in = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_count, overrun} !== {1'b1, e.cnt, 1'b0}) begin
            errors++;
            $display("FAIL b2b_load v=%b cnt=%0d ovr=%b want cnt=%0d ovr=0",
                     res_valid, res_count, overrun, e.cnt);
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain res_valid=%b want 0", res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_last_cycle();
        test_overrun();
        test_saturation();
        test_enable();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
